// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared widths and FSM state type for the 2-to-4 sequential dense layer
package dnn_pkg;
  localparam int DATA_W = 17;
  localparam int WGT_W  = 5;
  // Two DATA_W x WGT_W products summed never exceed 23 signed bits
  localparam int ACC_W  = 23;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_e;
endpackage

// File: rtl/dnn_mac_unit.sv
// rtl/dnn_mac_unit.sv - signed multiply with load/accumulate select, combinational
module dnn_mac_unit #(
  parameter int DATA_W = 17,
  parameter int WGT_W  = 5,
  parameter int ACC_W  = 23
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [WGT_W-1:0]  b_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic                     load_i,
  output logic signed [ACC_W-1:0]  sum_o
);
  logic signed [DATA_W+WGT_W-1:0] prod;
  logic signed [ACC_W-1:0]        prod_ext;

  assign prod     = a_i * b_i;
  assign prod_ext = ACC_W'(prod);
  assign sum_o    = load_i ? prod_ext : (acc_i + prod_ext);
endmodule

// File: rtl/dnn_2to4_seq.sv
// rtl/dnn_2to4_seq.sv - 2-input, 4-node dense layer evaluated over 8 cycles on one multiplier
module dnn_2to4_seq #(
  parameter int DATA_W = 17,
  parameter int WGT_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x8,
  input  logic signed [DATA_W-1:0] x9,
  input  logic                     in0_ready,
  input  logic                     in1_ready,
  input  logic signed [WGT_W-1:0]  w8_10,
  input  logic signed [WGT_W-1:0]  w8_11,
  input  logic signed [WGT_W-1:0]  w8_12,
  input  logic signed [WGT_W-1:0]  w8_13,
  input  logic signed [WGT_W-1:0]  w9_10,
  input  logic signed [WGT_W-1:0]  w9_11,
  input  logic signed [WGT_W-1:0]  w9_12,
  input  logic signed [WGT_W-1:0]  w9_13,
  output logic signed [DATA_W-1:0] y10,
  output logic signed [DATA_W-1:0] y11,
  output logic signed [DATA_W-1:0] y12,
  output logic signed [DATA_W-1:0] y13,
  output logic                     out_ready,
  output logic                     busy,
  output logic                     overrun
);
  import dnn_pkg::*;

  state_e                    state_q;
  logic [2:0]                k_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   sum_d;
  logic signed [DATA_W-1:0]  x8_q, x9_q;
  logic signed [WGT_W-1:0]   w8_q [4];
  logic signed [WGT_W-1:0]   w9_q [4];
  logic signed [DATA_W-1:0]  stage_q [4];
  logic signed [DATA_W-1:0]  y_q [4];
  logic                      out_ready_q;
  logic                      overrun_q;

  logic                      both_rdy;
  logic [1:0]                node;
  logic signed [DATA_W-1:0]  mac_a;
  logic signed [WGT_W-1:0]   mac_b;

  assign both_rdy = in0_ready & in1_ready;
  assign node     = k_q[2:1];
  assign mac_a    = k_q[0] ? x9_q : x8_q;
  assign mac_b    = k_q[0] ? w9_q[node] : w8_q[node];

  dnn_mac_unit #(
    .DATA_W(DATA_W),
    .WGT_W (WGT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .a_i   (mac_a),
    .b_i   (mac_b),
    .acc_i (acc_q),
    .load_i(~k_q[0]),
    .sum_o (sum_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= 3'd0;
      acc_q       <= '0;
      x8_q        <= '0;
      x9_q        <= '0;
      out_ready_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        w8_q[i]    <= '0;
        w9_q[i]    <= '0;
        stage_q[i] <= '0;
        y_q[i]     <= '0;
      end
    end else begin
      out_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (both_rdy) begin
            x8_q    <= x8;
            x9_q    <= x9;
            w8_q[0] <= w8_10;
            w8_q[1] <= w8_11;
            w8_q[2] <= w8_12;
            w8_q[3] <= w8_13;
            w9_q[0] <= w9_10;
            w9_q[1] <= w9_11;
            w9_q[2] <= w9_12;
            w9_q[3] <= w9_13;
            k_q     <= 3'd0;
            acc_q   <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (both_rdy) overrun_q <= 1'b1;
          k_q <= k_q + 3'd1;
          if (!k_q[0]) acc_q <= sum_d;
          else         stage_q[node] <= sum_d[DATA_W-1:0];
          // Node 13 finishes on this same edge, so it bypasses staging
          if (k_q == 3'd7) begin
            y_q[0]      <= stage_q[0];
            y_q[1]      <= stage_q[1];
            y_q[2]      <= stage_q[2];
            y_q[3]      <= sum_d[DATA_W-1:0];
            out_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign y10       = y_q[0];
  assign y11       = y_q[1];
  assign y12       = y_q[2];
  assign y13       = y_q[3];
  assign out_ready = out_ready_q;
  assign busy      = (state_q == ST_MAC);
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_dnn_2to4_seq.sv
// tb/tb_dnn_2to4_seq.sv - directed vector bench for dnn_2to4_seq
module tb_dnn_2to4_seq;
  logic               clk = 1'b0;
  logic               reset;
  logic signed [16:0] x8, x9;
  logic               in0_ready, in1_ready;
  logic signed [4:0]  w8_10, w8_11, w8_12, w8_13;
  logic signed [4:0]  w9_10, w9_11, w9_12, w9_13;
  logic signed [16:0] y10, y11, y12, y13;
  logic               out_ready, busy, overrun;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int x8;
    int x9;
    int w8[4];
    int w9[4];
    int y[4];
  } vec_t;

  vec_t vecs[5];

  dnn_2to4_seq #(.DATA_W(17), .WGT_W(5)) dut (
    .clk(clk), .reset(reset), .x8(x8), .x9(x9),
    .in0_ready(in0_ready), .in1_ready(in1_ready),
    .w8_10(w8_10), .w8_11(w8_11), .w8_12(w8_12), .w8_13(w8_13),
    .w9_10(w9_10), .w9_11(w9_11), .w9_12(w9_12), .w9_13(w9_13),
    .y10(y10), .y11(y11), .y12(y12), .y13(y13),
    .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_inputs(input vec_t v);
    x8 = 17'(v.x8);
    x9 = 17'(v.x9);
    w8_10 = 5'(v.w8[0]); w8_11 = 5'(v.w8[1]); w8_12 = 5'(v.w8[2]); w8_13 = 5'(v.w8[3]);
    w9_10 = 5'(v.w9[0]); w9_11 = 5'(v.w9[1]); w9_12 = 5'(v.w9[2]); w9_13 = 5'(v.w9[3]);
  endtask

  task automatic check_y(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, " y10"}, int'(y10), e0);
    check({tag, " y11"}, int'(y11), e1);
    check({tag, " y12"}, int'(y12), e2);
    check({tag, " y13"}, int'(y13), e3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Single transaction: strobes for one cycle, then watch edges 0..11
  task automatic run_txn(input vec_t v, input string tag);
    int busy_n = 0;
    int pulse_n = 0;
    int pulse_at = -1;
    set_inputs(v);
    in0_ready = 1'b1;
    in1_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
      end
      if (busy) busy_n++;
      if (out_ready) begin
        pulse_n++;
        if (pulse_at < 0) pulse_at = i;
      end
      if (i == 8) check_y(tag, v.y[0], v.y[1], v.y[2], v.y[3]);
    end
    check({tag, " out_ready pulses"}, pulse_n, 1);
    check({tag, " out_ready edge"}, pulse_at, 8);
    check({tag, " busy cycles"}, busy_n, 8);
  endtask

  initial begin
    int busy_n;
    int pulse_n;
    int pulses[$];

    vecs[0] = '{100, -50, '{3, -1, 0, 7}, '{2, 4, 0, -8}, '{200, -300, 0, 1100}};
    vecs[1] = '{65535, 65535, '{15, 15, 15, 15}, '{15, 15, 15, 15}, '{-30, -30, -30, -30}};
    vecs[2] = '{-65536, -65536, '{-16, -16, -16, -16}, '{-16, -16, -16, -16}, '{0, 0, 0, 0}};
    vecs[3] = '{1000, -2000, '{1, -16, 15, -1}, '{-1, 2, 0, 5}, '{3000, -20000, 15000, -11000}};
    vecs[4] = '{-65536, -65536, '{-16, 1, 0, 2}, '{15, 1, 0, -3}, '{-65536, 0, 0, -65536}};

    reset = 1'b1;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    set_inputs(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    check_y("reset", 0, 0, 0, 0);
    check("reset out_ready", int'(out_ready), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(overrun), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 5; n++) begin
      run_txn(vecs[n], $sformatf("vec%0d", n));
    end
    check("table overrun", int'(overrun), 0);

    // Lone strobe on one input only
    busy_n = 0;
    pulse_n = 0;
    set_inputs(vecs[0]);
    in0_ready = 1'b1;
    in1_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (out_ready) pulse_n++;
    end
    in0_ready = 1'b0;
    check("single busy", busy_n, 0);
    check("single out_ready", pulse_n, 0);
    check("single overrun", int'(overrun), 0);
    check_y("single", vecs[4].y[0], vecs[4].y[1], vecs[4].y[2], vecs[4].y[3]);

    // Second strobe pair at edge 4 carrying different data
    pulse_n = 0;
    set_inputs(vecs[0]);
    in0_ready = 1'b1;
    in1_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
      end
      if (i == 3) begin
        set_inputs(vecs[3]);
        in0_ready = 1'b1;
        in1_ready = 1'b1;
      end
      if (i == 4) begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
      end
      if (out_ready) pulse_n++;
    end
    check("overrun pulses", pulse_n, 1);
    check("overrun flag", int'(overrun), 1);
    check_y("overrun", 200, -300, 0, 1100);
    do_reset();
    check("overrun cleared", int'(overrun), 0);

    // Strobes held high: one result every 9 cycles
    set_inputs(vecs[1]);
    in0_ready = 1'b1;
    in1_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_ready) pulses.push_back(i);
    end
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    check("b2b pulse count", pulses.size(), 4);
    if (pulses.size() > 0) check("b2b first pulse", pulses[0], 8);
    for (int p = 1; p < pulses.size(); p++) begin
      check($sformatf("b2b gap%0d", p), pulses[p] - pulses[p-1], 9);
    end
    check("b2b overrun", int'(overrun), 1);
    check_y("b2b", -30, -30, -30, -30);
    for (int i = 0; i < 10; i++) @(negedge clk);

    // Reset landing on MAC edge 5
    set_inputs(vecs[3]);
    in0_ready = 1'b1;
    in1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
      end
      if (i == 4) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check_y("midreset", 0, 0, 0, 0);
    check("midreset out_ready", int'(out_ready), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset overrun", int'(overrun), 0);
    pulse_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_ready) pulse_n++;
    end
    check("midreset no pulse", pulse_n, 0);
    run_txn(vecs[3], "after reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
